// File: rtl/opc5_bus_pkg.sv
// opc5_bus_pkg: shared port ids, bus widths and request record for OPC5 bus masters.
package opc5_bus_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;
  typedef struct packed {
    logic              rnw;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/opc5_rr_pick.sv
// opc5_rr_pick: combinational two-way round-robin picker with a hold-owner bias.
module opc5_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       hold,
  output logic [1:0] gnt
);
  logic [1:0] owner;
  assign owner = last ? 2'b10 : 2'b01;
  always_comb gnt = &req ? (hold ? owner : ~owner) : req;
endmodule

// File: rtl/opc5_mem_arbiter.sv
// opc5_mem_arbiter: shares one single-port synchronous memory between the CPU and an aux master.
module opc5_mem_arbiter
  import opc5_bus_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          rnw0,
  input  logic          rnw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          mem_ce,
  output logic          mem_rnw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [3:0] BM = 4'(BURST_MAX);
  logic       last_q;
  logic [3:0] cnt_q;
  logic [1:0] rpend_q;
  logic [1:0] gnt;
  logic       hold;
  logic       win;
  // The previous owner keeps the memory only while it asks to and its burst budget lasts.
  assign hold = (last_q ? lock1 : lock0) && (cnt_q < BM);
  opc5_rr_pick u_pick (
    .req  ({req1, req0}),
    .last (last_q),
    .hold (hold),
    .gnt  (gnt)
  );
  assign win    = gnt[PORT_AUX];
  assign gnt0   = gnt[PORT_CPU];
  assign gnt1   = gnt[PORT_AUX];
  assign mem_ce = |gnt;
  always_comb begin
    mem_rnw   = gnt[PORT_AUX] ? rnw1   : gnt[PORT_CPU] ? rnw0   : 1'b0;
    mem_addr  = gnt[PORT_AUX] ? addr1  : gnt[PORT_CPU] ? addr0  : '0;
    mem_wdata = gnt[PORT_AUX] ? wdata1 : gnt[PORT_CPU] ? wdata0 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= PORT_AUX;
      cnt_q   <= '0;
      rpend_q <= '0;
    end else begin
      rpend_q <= gnt & {rnw1, rnw0};
      if (!mem_ce) begin
        cnt_q <= '0;
      end else if (win == last_q) begin
        cnt_q <= (cnt_q == BM) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_q  <= 4'd1;
        last_q <= win;
      end
    end
  end
  // A return still in flight while reset is asserted is dropped immediately.
  assign rvalid0 = rpend_q[PORT_CPU] & ~reset;
  assign rvalid1 = rpend_q[PORT_AUX] & ~reset;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// tb_opc5_mem_arbiter: table-driven arbitration vectors with a read-return scoreboard.
module tb_opc5_mem_arbiter;
  logic        clk, reset;
  logic        req0, req1, lock0, lock1, rnw0, rnw1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_ce, mem_rnw;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  opc5_mem_arbiter #(.BURST_MAX(4), .AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rnw0(rnw0), .rnw1(rnw1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_ce(mem_ce), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit rb, r0, r1, l0, l1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    bit g0, g1;
  } vec_t;
  typedef struct {
    int cyc;
    bit port;
    logic [15:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  logic [15:0] mem [0:65535];
  logic [15:0] wr [logic [15:0]];
  int total = 0, bad = 0, cyc = 0;
  bit run = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_ce) begin
      if (mem_rnw) mem_rdata <= mem[mem_addr];
      else mem[mem_addr] <= mem_wdata;
    end

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return wr.exists(a) ? wr[a] : pat(a);
  endfunction

  function automatic vec_t mk(input bit rb, r0, r1, l0, l1, w0, w1,
                              input logic [15:0] a0, a1, d0, d1, input bit g0, g1);
    vec_t v;
    v.rb = rb; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; rnw0 = 1; rnw1 = 1;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic apply(input vec_t v);
    bit p, rnw;
    logic [15:0] a, d;
    @(posedge clk); #1;
    req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1; rnw0 = v.w0; rnw1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(negedge clk);
    chk("gnt0", gnt0, v.g0);
    chk("gnt1", gnt1, v.g1);
    chk("mem_ce", mem_ce, v.g0 | v.g1);
    if (v.g0 | v.g1) begin
      p = v.g1;
      a = p ? v.a1 : v.a0;
      d = p ? v.d1 : v.d0;
      rnw = p ? v.w1 : v.w0;
      chk("mem_addr", mem_addr, a);
      chk("mem_rnw", mem_rnw, rnw);
      if (rnw) sb.push_back('{cyc + 1, p, ref_rd(a)});
      else begin
        chk("mem_wdata", mem_wdata, d);
        wr[a] = d;
      end
    end
  endtask

  // Read-return monitor: every cycle the strobes must match exactly what the scoreboard expects.
  sb_t e;
  bit ev0, ev1;
  always @(negedge clk)
    if (run) begin
      ev0 = 0; ev1 = 0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        ev0 = (e.port == 0);
        ev1 = (e.port == 1);
      end
      chk("rvalid0", rvalid0, ev0);
      chk("rvalid1", rvalid1, ev1);
      if (ev0) chk("rdata0", rdata0, e.data);
      if (ev1) chk("rdata1", rdata1, e.data);
    end

  localparam vec_t IDLE = '{rb:0, r0:0, r1:0, l0:0, l1:0, w0:1, w1:1,
                            a0:16'h0, a1:16'h0, d0:16'h0, d1:16'h0, g0:0, g1:0};

  initial begin
    reset = 1;
    idle_inputs();
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    mem[16'h1234] = 16'hBEEF;
    wr[16'h1234] = 16'hBEEF;

    for (int i = 0; i < 10; i++) vecs.push_back(IDLE);
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 16'h1234, 16'h0, 16'h0, 16'h0, 1, 0));
    vecs.push_back(IDLE);
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(i == 0, 1, 1, 0, 0, 1, 1, 16'h0100, 16'h0200, 16'h0, 16'h0, i % 2 == 0, i % 2 == 1));
    vecs.push_back(IDLE);
    for (int i = 0; i < 11; i++)
      vecs.push_back(mk(i == 0, 1, 1, 1, 0, 1, 1, 16'h0101, 16'h0201, 16'h0, 16'h0, i % 5 != 4, i % 5 == 4));
    vecs.push_back(IDLE);
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 16'h0, 16'h0010, 16'h0, 16'h00A5, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 16'h0010, 16'h0, 16'h0, 16'h0, 1, 0));
    vecs.push_back(IDLE);
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 16'h0, 16'h0020, 16'h0, 16'h0, 0, 1));
    vecs.push_back(IDLE);
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 16'h0, 16'h0030 + 16'(i), 16'h0, 16'h0, 0, 1));
    vecs.push_back(IDLE);
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 16'h0040, 16'h0041, 16'h1111, 16'h0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 16'h0040, 16'h0041, 16'h0, 16'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 16'h0040, 16'h0, 16'h0, 16'h0, 1, 0));
    vecs.push_back(IDLE);

    do_reset();
    run = 1;
    foreach (vecs[i]) begin
      if (vecs[i].rb) do_reset();
      apply(vecs[i]);
    end

    // Reset arriving the cycle after a granted read discards its return.
    apply(mk(0, 0, 1, 0, 0, 1, 1, 16'h0, 16'h0300, 16'h0, 16'h0, 0, 1));
    @(posedge clk); #1;
    reset = 1;
    idle_inputs();
    sb.delete();
    @(negedge clk);
    chk("rst_rvalid1_a", rvalid1, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_rvalid1_b", rvalid1, 1'b0);
    apply(IDLE);

    chk("sb_drain", sb.size(), 0);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/opc5_mem_arbiter.md
# opc5_mem_arbiter

Two-port arbiter sharing one single-port synchronous 64K×16 memory between the OPC5 CPU (port 0) and a second bus master such as DMA or video fetch (port 1). Sits between the masters and the memory macro. Decides one access per cycle using round-robin with a bounded lock/burst window. Returns read data one cycle after grant with a per-port valid strobe. The CPU side uses a stall-aware wrapper that holds the address and `rnw` until it sees a grant.

## Interface
- `BURST_MAX`, default 4: max consecutive grants to one port while its `lock` is high and the other port is requesting; legal range 1–15.
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req0`/`req1`  in  1: access request, held until granted.
- `lock0`/`lock1`  in  1: request to keep ownership for the next access; only sampled with `req`.
- `rnw0`/`rnw1`  in  1: 1 means read, 0 means write.
- `addr0`/`addr1`  in  AW: access address.
- `wdata0`/`wdata1`  in  DW: write data.
- `gnt0`/`gnt1`  out  1: access issued this cycle (combinational from current inputs and state).
- `rdata0`/`rdata1`  out  DW: read data, valid when `rvalid` is high.
- `rvalid0`/`rvalid1`  out  1: registered; high one cycle after a granted read.
- `mem_ce`  out  1: memory access strobe.
- `mem_rnw`  out  1: memory read/write select.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: memory write data.
- `mem_rdata`  in  DW: memory read data, valid the cycle after `mem_ce` with `mem_rnw`=1.

## Operation
- **State:**
  - `last_q`: port granted most recently.
  - `cnt_q`: consecutive grants to `last_q`, 0..BURST_MAX.
  - `rpend_q[1:0]`: one-hot read-return tag.
- **Arbitration each cycle:**
  - No request: no grant, `mem_ce`=0.
  - One port requesting: that port is granted.
  - Both requesting, and `last_q` port has `lock` high and `cnt_q` < BURST_MAX: `last_q` port is granted.
  - Both requesting, otherwise: the port ≠ `last_q` is granted.
- **On grant:**
  - `mem_*` is driven from the granted port's `rnw`/`addr`/`wdata`; `mem_ce`=1.
  - If the granted port == `last_q`, `cnt_q` increments, saturating at BURST_MAX; otherwise `cnt_q` := 1 and `last_q` := granted port.
- **No grant:** `cnt_q` := 0; `last_q` holds.
- **Read return:**
  - A granted read sets `rpend_q[port]`.
  - Next cycle, `rvalid<port>` is driven from it and `rdata<port>` = `mem_rdata`.
  - `rdata` of the non-returning port is don't-care; the bench checks it only with `rvalid`.
- **Writes:** a write completes at grant and produces no `rvalid`.
- **Ungranted cycles:** `mem_addr`/`mem_wdata`/`mem_rnw` are don't-care; drive 0 for lint cleanliness.
- **Lock without contention:** `lock` does not block a request-free other port; it only biases ties.

## Timing
- **Reset values:**
  - `last_q`=1, so port 0 wins the first tie.
  - `cnt_q`=0 and `rpend_q`=0.
  - `rvalid0`=`rvalid1`=0.
  - `gnt`/`mem_ce` are 0 whenever no `req` is high.
- **Latency:**
  - Grant has 0 cycles of latency from `req` when uncontended.
  - Read data arrives exactly 1 cycle after grant.
- **Throughput:** one access per cycle. Back-to-back reads from the same port give back-to-back `rvalid`.
- **Handshake:**
  - The master holds `req`/`rnw`/`addr`/`wdata` stable until a rising edge where its `gnt` is high.
  - The master may drop `req` or change the address on the following cycle.
- **Starvation bound:** a requesting port waits at most BURST_MAX cycles.
- **Reset mid-operation:** a pending read return is discarded; `rvalid` is 0 on the cycle after `reset`. Any write granted in the same cycle as `reset` still reaches memory, because `mem_ce` is combinational; masters must not rely on it.
- **BURST_MAX=1:** the arbiter alternates strictly under contention regardless of `lock`.

## Structure
- Package `opc5_bus_pkg`:
  - `PORT_CPU`=0 and `PORT_AUX`=1 constants.
  - `AW`/`DW` defaults.
  - Packed request struct type {`rnw`, `addr`, `wdata`}, shared with the CPU stall wrapper and the DMA.
- Sub-module `opc5_rr_pick`:
  - Combinational 2-way picker.
  - Inputs: `req[1:0]`, `last`, `hold`.
  - Output: one-hot `gnt[1:0]`.
  - The top level owns `last_q`, `cnt_q`, the `hold` computation, the mux and the read-return pipeline.

## Test plan
- **Reset/idle:** after `reset`, all `req`=0 → `gnt`=0, `mem_ce`=0, `rvalid`=0 for 10 cycles.
- **Single read:** `req0`=1, `rnw0`=1, `addr0`=0x1234, memory model returns 0xBEEF → `gnt0`=1 in the same cycle; `rvalid0`=1 and `rdata0`=0xBEEF the next cycle; `rvalid1` stays 0.
- **Tie after reset:** both requesting, no `lock` → grant order 0,1,0,1,… each cycle.
- **Burst lock, BURST_MAX=4:** `lock0`=1, both requesting continuously → `gnt0` ×4, `gnt1` ×1, `gnt0` ×4, and so on.
- **Write then read same address:** port 1 writes 0x00A5 to 0x0010, then port 0 reads 0x0010 → `rdata0`=0x00A5; no `rvalid1` for the write.
- **Reset mid-read:** grant a read on port 1 with `reset`=1 on the next cycle → `rvalid1`=0 on that cycle and the one after.
